// File: rtl/comparator_bist.sv
// Built-in self-test sweep for a WIDTH-bit magnitude comparator: drives every (A,B) pair,
// checks GT/LT/EQ against an internal unsigned compare, counts mismatches, latches the first.
module comparator_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               gt_in,
    input  logic               lt_in,
    input  logic               eq_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
    localparam logic [WIDTH-1:0] ONES       = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    state_t           state;
    logic [3:0]       cnt;
    logic             exp_gt, exp_lt, exp_eq;
    logic             mismatch;
    logic [2*WIDTH:0] err_next;

    // Expectation is derived from the registered operands, so it matches what the DUT saw.
    always_comb begin
        exp_gt   = a_out > b_out;
        exp_lt   = a_out < b_out;
        exp_eq   = a_out == b_out;
        mismatch = {gt_in, lt_in, eq_in} != {exp_gt, exp_lt, exp_eq};
        err_next = err_count + {{(2*WIDTH){1'b0}}, mismatch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        cnt       <= SETTLE_CNT;
                        a_out     <= '0;
                        b_out     <= '0;
                        err_count <= '0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (err_count == '0) begin
                            fail_a <= a_out;
                            fail_b <= b_out;
                        end
                    end
                    // B is the inner loop; the final pair closes the sweep on this edge.
                    if (b_out != ONES) begin
                        b_out <= b_out + ONE;
                        cnt   <= SETTLE_CNT;
                        state <= WAIT;
                    end else if (a_out != ONES) begin
                        b_out <= '0;
                        a_out <= a_out + ONE;
                        cnt   <= SETTLE_CNT;
                        state <= WAIT;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench: golden and faulty comparator models around two BIST instances (SETTLE=1 and 3).
module tb_comparator_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;
    int         mode;
    int         checks = 0;
    int         errors = 0;

    logic [3:0] a1, b1, a3, b3;
    logic       g1, l1, e1, g3, l3, e3;
    logic       busy1, done1, pass1, busy3, done3, pass3;
    logic [8:0] err1, err3;
    logic [3:0] fa1, fb1, fa3, fb3;
    logic [2:0] p1_q1, p1_q2, p3_q1, p3_q2;

    logic       busy_s, done_s, pass_s;
    logic [8:0] err_s;

    always #5 clk = ~clk;

    comparator_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .a_out(a1), .b_out(b1), .gt_in(g1), .lt_in(l1), .eq_in(e1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1)
    );

    comparator_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .a_out(a3), .b_out(b3), .gt_in(g3), .lt_in(l3), .eq_in(e3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_a(fa3), .fail_b(fb3)
    );

    // Two-stage registered comparators for the settle-time tests.
    always @(posedge clk) begin
        p1_q1 <= {a1 > b1, a1 < b1, a1 == b1};
        p1_q2 <= p1_q1;
        p3_q1 <= {a3 > b3, a3 < b3, a3 == b3};
        p3_q2 <= p3_q1;
    end

    // mode: 0 golden, 1 eq stuck at 0, 2 gt/lt swapped, 3 two-cycle delayed golden
    always_comb begin
        g1 = a1 > b1;
        l1 = a1 < b1;
        e1 = a1 == b1;
        case (mode)
            1: e1 = 1'b0;
            2: begin g1 = a1 < b1; l1 = a1 > b1; end
            3: {g1, l1, e1} = p1_q2;
            default: ;
        endcase
        {g3, l3, e3} = p3_q2;
    end

    assign busy_s = sel ? busy3 : busy1;
    assign done_s = sel ? done3 : done1;
    assign pass_s = sel ? pass3 : pass1;
    assign err_s  = sel ? err3  : err1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},    a1, 0);
        check({tag, "_b"},    b1, 0);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_pass"}, pass1, 0);
        check({tag, "_err"},  err1, 0);
        check({tag, "_fa"},   fa1, 0);
        check({tag, "_fb"},   fb1, 0);
    endtask

    task automatic run_sweep(input bit repulse, output int nbusy, output int ndone);
        int cyc;
        bit seen;
        nbusy = 0; ndone = 0; seen = 0; cyc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!seen && cyc < 5000) begin
            if (busy_s) nbusy++;
            if (done_s) begin ndone++; seen = 1'b1; end
            start = (repulse && nbusy == 100);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!seen) check("sweep_timeout", 0, 1);
        repeat (3) begin
            if (done_s) ndone++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done_s && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_s) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int nb, nd, cyc;
        rst_n = 1'b0; start = 1'b0; sel = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Golden sweep with a start re-pulse while busy
        run_sweep(1'b1, nb, nd);
        check("gold_busy", nb, 512);
        check("gold_done", nd, 1);
        check("gold_pass", pass1, 1);
        check("gold_err", err1, 0);
        check("gold_fa", fa1, 0);
        check("gold_fb", fb1, 0);
        check("gold_a_hold", a1, 15);
        check("gold_b_hold", b1, 15);

        mode = 1;
        run_sweep(1'b0, nb, nd);
        check("eq0_err", err1, 16);
        check("eq0_pass", pass1, 0);
        check("eq0_fa", fa1, 0);
        check("eq0_fb", fb1, 0);

        mode = 2;
        run_sweep(1'b0, nb, nd);
        check("swap_err", err1, 240);
        check("swap_pass", pass1, 0);
        check("swap_fa", fa1, 0);
        check("swap_fb", fb1, 1);

        // Reset during the CHECK cycle of pair (6,4); 94 unequal pairs precede it
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(a1 == 4'd6 && b1 == 4'd4) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check("mid_timeout", 0, 1);
        @(posedge clk);
        #1;
        check("mid_err", err1, 94);
        check("mid_busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        mode = 0;
        run_sweep(1'b0, nb, nd);
        check("post_rst_busy", nb, 512);
        check("post_rst_pass", pass1, 1);

        // start held high: second sweep relaunches from IDLE with counters cleared
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_done("held1");
        check("held_err", err1, 16);
        check("held_pass", pass1, 0);
        mode = 0;
        @(negedge clk);
        check("held_idle_busy", busy1, 0);
        @(negedge clk);
        check("held_restart_busy", busy1, 1);
        check("held_restart_err", err1, 0);
        start = 1'b0;
        wait_done("held2");
        check("held2_pass", pass1, 1);
        @(negedge clk);

        mode = 3;
        run_sweep(1'b0, nb, nd);
        check("dly_s1_pass", pass1, 0);
        check("dly_s1_err_nz", err1 != 0, 1);

        sel = 1'b1;
        run_sweep(1'b0, nb, nd);
        check("dly_s3_busy", nb, 1024);
        check("dly_s3_done", nd, 1);
        check("dly_s3_pass", pass_s, 1);
        check("dly_s3_err", err_s, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator_bist.md
# comparator_bist

Built-in self-test sequencer for the parameterized magnitude comparator: drives the comparator's A/B inputs and checks its GT/LT/EQ outputs. On a start pulse it sweeps every (A, B) operand pair and checks each response against an internally computed expectation. It counts mismatches and records the first failing pair. It sits beside the comparator on the test path and reports pass/fail to the test controller.

## Interface

Parameters:
- WIDTH, 4, operand width; the sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 1, wait cycles between driving a pair and sampling the response; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request; accepted only in IDLE.
- a_out  output  WIDTH  operand A to the comparator under test.
- b_out  output  WIDTH  operand B to the comparator under test.
- gt_in  input  1  comparator GT response.
- lt_in  input  1  comparator LT response.
- eq_in  input  1  comparator EQ response.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  result of the last completed sweep (1 = zero mismatches).
- err_count  output  2*WIDTH+1  mismatches in the current or last sweep.
- fail_a  output  WIDTH  A operand of the first mismatching pair.
- fail_b  output  WIDTH  B operand of the first mismatching pair.

## Operation

- States: IDLE, WAIT, CHECK, DONE.
- IDLE to WAIT when start=1 at a clock edge:
  - a_out=0, b_out=0, wait counter=SETTLE.
  - err_count, fail_a, fail_b and pass cleared to 0; busy=1.
- WAIT: decrement the counter each cycle; go to CHECK when the counter reaches 1. Exactly SETTLE cycles are spent in WAIT per pair.
- CHECK, one cycle. Expected values come from the registered a_out/b_out as unsigned compares: exp_gt=(a>b), exp_lt=(a<b), exp_eq=(a==b).
- Mismatch = any response bit differs from its expectation. This includes multi-hot and all-zero responses.
- On a mismatch:
  - err_count increments. It cannot overflow: its maximum, 2^(2*WIDTH), fits.
  - If err_count was 0, fail_a/fail_b capture a_out/b_out.
- Pair ordering: b_out is the inner loop and a_out the outer loop. After CHECK:
  - b_out<all-ones: b_out+1, go to WAIT.
  - b_out=all-ones and a_out<all-ones: b_out wraps to 0, a_out+1, go to WAIT.
  - Both all-ones: go to DONE.
- DONE, one cycle: done=1, busy=0, pass=(err_count==0). Then IDLE. a_out/b_out hold their last value (all-ones).
- start is ignored while busy. start still high on return to IDLE launches a new sweep, so back-to-back sweeps are legal.
- Reset (asynchronous, any state, including mid-sweep) forces the following, with no partial result retained:
  - State IDLE.
  - a_out=0, b_out=0.
  - busy=0, done=0, pass=0.
  - err_count=0, fail_a=0, fail_b=0.

## Timing

- Reset value of every output is 0.
- All outputs are registered.
- The new pair appears on a_out/b_out on the edge leaving IDLE or CHECK.
- The response is sampled at the end of the CHECK cycle, SETTLE+1 cycles after the operands change. The comparator's combinational path must settle within SETTLE cycles.
- Per pair: SETTLE+1 cycles.
- busy is high for exactly 2^(2*WIDTH)*(SETTLE+1) cycles, starting the cycle after start is sampled.
- done and pass update on the same edge that drops busy.
- err_count and fail_a/fail_b update on the edge closing the CHECK cycle; they are visible mid-sweep.
- pass stays stable from DONE until the next accepted start.

## Test plan

- Golden comparator attached, WIDTH=4, SETTLE=1, start pulsed one cycle:
  - busy high exactly 512 cycles; done pulses once.
  - pass=1, err_count=0, fail_a=fail_b=0.
- eq_in forced 0:
  - err_count=16, pass=0, fail_a=0, fail_b=0.
  - The first mismatch is latched, not overwritten by later ones.
- gt_in and lt_in swapped:
  - err_count=240, fail_a=0, fail_b=1.
- rst_n pulsed low during the CHECK cycle of pair a=6, b=4 (mid-sweep):
  - All outputs 0 immediately (asynchronous).
  - A following start gives a full 512-cycle sweep with pass=1.
- Start handling:
  - start re-pulsed while busy: ignored, sweep length unchanged.
  - start held high continuously: second sweep begins the cycle after DONE, with err_count cleared.
- SETTLE=3 with a golden comparator that has a 2-cycle registered delay:
  - busy high 1024 cycles, pass=1.
  - The same comparator with SETTLE=1 gives pass=0 and err_count>0.
